axi4_lite_xbar: RTL

AXI4_LITE_XBAR -- requirements
Module: axi4_lite_xbar

---
 rtl/axi4_lite_xbar_pkg.sv | 24 ++
 rtl/axi4_lite_xbar_addr_decode.sv | 35 +++
 rtl/axi4_lite_xbar.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_xbar_pkg.sv
// Shared definitions for the AXI4-Lite crossbar: FSM state encoding,
// slave target encoding, AXI response codes and the default CLINT base.
package axi4_lite_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TGT_MEM   = 2'd0,
        TGT_CLINT = 2'd1,
        TGT_NONE  = 2'd2
    } target_e;

    localparam logic [1:0]  RESP_OKAY          = 2'b00;
    localparam logic [1:0]  RESP_SLVERR        = 2'b10;
    localparam logic [1:0]  RESP_DECERR        = 2'b11;

    localparam logic [31:0] CLINT_BASE_DEFAULT = 32'h2000_0000;

endpackage

// File: rtl/axi4_lite_xbar_addr_decode.sv
// Combinational address decoder for the AXI4-Lite crossbar.
// Ports:
//   addr_i   - 32-bit request address
//   target_o - TGT_CLINT for the 8-byte CLINT window, TGT_MEM for the
//              memory window, TGT_NONE otherwise
module axi4_lite_addr_decode
    import axi4_lite_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic [31:0] addr_i,
    output target_e     target_o
);

    // 33-bit arithmetic so MEM_BASE + MEM_SIZE cannot wrap past 2^32.
    logic [32:0] addr_ext;
    logic [32:0] mem_lo;
    logic [32:0] mem_hi;

    assign addr_ext = {1'b0, addr_i};
    assign mem_lo   = {1'b0, MEM_BASE};
    assign mem_hi   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    always_comb begin
        target_o = TGT_NONE;
        if (addr_i[31:3] == CLINT_BASE[31:3]) begin
            target_o = TGT_CLINT;
        end else if ((addr_ext >= mem_lo) && (addr_ext < mem_hi)) begin
            target_o = TGT_MEM;
        end
    end

endmodule

// File: rtl/axi4_lite_xbar.sv
// Single-outstanding AXI4-Lite crossbar: one master, two slaves
// (s0 = memory, s1 = CLINT), with decode error and response timeout.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   m_aw*/m_w*/m_ar*       - master requests; m_awready/m_arready high in IDLE
//   m_b*/m_r*              - master responses, one-cycle pulses in RESP
//   sN_aw*/sN_w*/sN_ar*    - slave requests, one-cycle pulse after acceptance
//   sN_b*/sN_r*            - slave responses, sampled only from selected slave
//   dbg_state              - current FSM state
//
// Handshake: a master request is taken on a cycle where its valid and the
// matching ready are both high (write needs m_awvalid and m_wvalid together;
// a read wins a tie and the write stays pending). Slave valids are single-
// cycle issue pulses; the slave answers with a valid pulse whenever ready,
// and the crossbar takes the first one seen. Master response valids are a
// single-cycle pulse with no ready back-pressure.
module axi4_lite_xbar
    import axi4_lite_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_awvalid,
    input  logic [31:0] m_awaddr,
    input  logic        m_wvalid,
    input  logic [31:0] m_wdata,
    input  logic        m_arvalid,
    input  logic [31:0] m_araddr,
    output logic        m_awready,
    output logic        m_arready,
    output logic        m_bvalid,
    output logic [1:0]  m_bresp,
    output logic        m_rvalid,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        s0_awvalid,
    output logic [31:0] s0_awaddr,
    output logic        s0_wvalid,
    output logic [31:0] s0_wdata,
    output logic        s0_arvalid,
    output logic [31:0] s0_araddr,
    input  logic        s0_bvalid,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_rvalid,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    output logic        s1_awvalid,
    output logic [31:0] s1_awaddr,
    output logic        s1_wvalid,
    output logic [31:0] s1_wdata,
    output logic        s1_arvalid,
    output logic [31:0] s1_araddr,
    input  logic        s1_bvalid,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_rvalid,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    output state_e      dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    target_e           tgt_q, tgt_d;
    logic              is_read_q, is_read_d;
    logic              issue_q, issue_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [1:0]        bresp_q, bresp_d;

    logic [31:0]       acc_addr;
    target_e           acc_tgt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              sel_rvalid, sel_bvalid;
    logic [31:0]       sel_rdata;
    logic [1:0]        sel_rresp, sel_bresp;

    // Reads take priority, so decode the read address whenever one is valid.
    assign acc_addr = m_arvalid ? m_araddr : m_awaddr;

    axi4_lite_addr_decode #(
        .CLINT_BASE (CLINT_BASE),
        .MEM_BASE   (MEM_BASE),
        .MEM_SIZE   (MEM_SIZE)
    ) u_decode (
        .addr_i   (acc_addr),
        .target_o (acc_tgt)
    );

    // Responses from the non-selected slave are never looked at.
    assign sel_rvalid = (tgt_q == TGT_CLINT) ? s1_rvalid : s0_rvalid;
    assign sel_rdata  = (tgt_q == TGT_CLINT) ? s1_rdata  : s0_rdata;
    assign sel_rresp  = (tgt_q == TGT_CLINT) ? s1_rresp  : s0_rresp;
    assign sel_bvalid = (tgt_q == TGT_CLINT) ? s1_bvalid : s0_bvalid;
    assign sel_bresp  = (tgt_q == TGT_CLINT) ? s1_bresp  : s0_bresp;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        is_read_d = is_read_q;
        issue_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        case (state_q)
            IDLE: begin
                if (m_arvalid || (m_awvalid && m_wvalid)) begin
                    is_read_d = m_arvalid;
                    tgt_d     = acc_tgt;
                    addr_d    = acc_addr;
                    cnt_d     = '0;
                    if (!m_arvalid) begin
                        wdata_d = m_wdata;
                    end
                    if (acc_tgt == TGT_NONE) begin
                        // Unmapped: answer directly, no slave is touched.
                        state_d = RESP;
                        if (m_arvalid) begin
                            rdata_d = '0;
                            rresp_d = RESP_DECERR;
                        end else begin
                            bresp_d = RESP_DECERR;
                        end
                    end else begin
                        issue_d = 1'b1;
                        state_d = m_arvalid ? RD_WAIT : WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (sel_rvalid) begin
                    state_d = RESP;
                    rdata_d = sel_rdata;
                    rresp_d = sel_rresp;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WR_WAIT: begin
                if (sel_bvalid) begin
                    state_d = RESP;
                    bresp_d = sel_bresp;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d = RESP;
                    bresp_d = RESP_SLVERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            tgt_q     <= TGT_MEM;
            is_read_q <= 1'b0;
            issue_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            is_read_q <= is_read_d;
            issue_q   <= issue_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
        end
    end

    assign m_arready  = (state_q == IDLE);
    assign m_awready  = (state_q == IDLE);
    assign m_rvalid   = (state_q == RESP) &&  is_read_q;
    assign m_bvalid   = (state_q == RESP) && !is_read_q;
    assign m_rdata    = rdata_q;
    assign m_rresp    = rresp_q;
    assign m_bresp    = bresp_q;

    assign s0_arvalid = issue_q &&  is_read_q && (tgt_q == TGT_MEM);
    assign s0_awvalid = issue_q && !is_read_q && (tgt_q == TGT_MEM);
    assign s0_wvalid  = s0_awvalid;
    assign s1_arvalid = issue_q &&  is_read_q && (tgt_q == TGT_CLINT);
    assign s1_awvalid = issue_q && !is_read_q && (tgt_q == TGT_CLINT);
    assign s1_wvalid  = s1_awvalid;
    assign s0_araddr  = addr_q;
    assign s0_awaddr  = addr_q;
    assign s0_wdata   = wdata_q;
    assign s1_araddr  = addr_q;
    assign s1_awaddr  = addr_q;
    assign s1_wdata   = wdata_q;

    assign dbg_state  = state_q;

endmodule
